slt_sort_stage: RTL and testbench

- Sequential buffer-and-sort stage that sits directly downstream of the structural signed less-than comparator (slt) and consumes its one-bit result.
- Collects a burst of up to DEPTH signed two's-complement words and bubble-sorts them in place, one slt compare-and-swap per cycle.
- Streams the words out in ascending signed order.
- Used as a reusable ordering stage in front of datapath consumers that need sorted operands.

---
 rtl/slt_sort_stage.sv | 165 ++++++++++++++++
 tb/tb_slt_sort_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slt_sort_stage.sv
// Buffer-and-sort stage: collects up to DEPTH signed words, bubble-sorts them with one slt compare-and-swap per cycle, streams them out ascending.
// Latency: len-1 to len*(len-1)/2 SORT cycles after the last accept. No overlap between loading and draining.
// Backpressure: in_ready only in LOAD; the output holds while out_ready is low. SLT_SORT_STATS_EN adds the swap_count port.

module slt #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         lt
);
  logic [N-1:0] diff;

  // Same-sign operands cannot overflow on subtraction; mixed signs decide on a's sign alone.
  assign diff = a - b;
  assign lt   = (a[N-1] ^ b[N-1]) ? a[N-1] : diff[N-1];
endmodule

module slt_sort_stage #(
  parameter int N     = 32,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last,
  output logic         busy
`ifdef SLT_SORT_STATS_EN
  ,
  output logic [$clog2(DEPTH*DEPTH):0] swap_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   mem [DEPTH];
  logic [CW-1:0]  count;
  logic [CW-1:0]  len;
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  pass;
  logic [AW-1:0]  j;
  logic [AW-1:0]  j1;
  logic           swapped;
  logic           lt;
  logic           in_acc, out_acc, load_end, pass_end, sort_done;
  logic [CW-1:0]  last_j;

  assign j1 = j + 1'b1;

  slt #(.N(N)) u_slt (
    .a  (mem[j1]),
    .b  (mem[j]),
    .lt (lt)
  );

  assign in_acc    = in_valid && in_ready;
  assign out_acc   = out_valid && out_ready;
  assign load_end  = in_acc && (in_last || (count == CW'(DEPTH - 1)));
  assign last_j    = len - CW'(2) - {1'b0, pass};
  assign pass_end  = (state == SORT) && ({1'b0, j} == last_j);
  // A swap on the final compare of a pass still means the burst may be unsorted.
  assign sort_done = pass_end && (!(swapped || lt) || ({1'b0, pass} == len - CW'(2)));

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (load_end) state_nxt = (count == '0) ? DRAIN : SORT;
      SORT:    if (sort_done) state_nxt = DRAIN;
      DRAIN:   if (out_acc && out_last) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = 1'b0;
    case (state)
      LOAD:  in_ready = 1'b1;
      SORT:  busy = 1'b1;
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = mem[rd_ptr];
        out_last  = ({1'b0, rd_ptr} == len - CW'(1));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      rd_ptr  <= '0;
      swapped <= 1'b0;
      len     <= '0;
      pass    <= '0;
      j       <= '0;
    end else begin
      case (state)
        LOAD: if (in_acc) begin
          count   <= count + 1'b1;
          pass    <= '0;
          j       <= '0;
          swapped <= 1'b0;
          if (load_end) len <= count + 1'b1;
        end
        SORT: begin
          if (pass_end) begin
            if (!sort_done) begin
              pass    <= pass + 1'b1;
              j       <= '0;
              swapped <= 1'b0;
            end
          end else begin
            j       <= j1;
            swapped <= swapped || lt;
          end
        end
        DRAIN: if (out_acc) begin
          if (out_last) begin
            count  <= '0;
            rd_ptr <= '0;
          end else begin
            rd_ptr <= rd_ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Buffer contents are don't-care after reset, so no reset term here.
  always_ff @(posedge clk) begin
    if (in_acc) begin
      mem[count[AW-1:0]] <= in_data;
    end else if (state == SORT && lt) begin
      mem[j]  <= mem[j1];
      mem[j1] <= mem[j];
    end
  end

`ifdef SLT_SORT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)                          swap_count <= '0;
    else if (in_acc && count == '0)   swap_count <= '0;
    else if (state == SORT && lt)     swap_count <= swap_count + 1'b1;
  end
`endif
endmodule

// File: tb/tb_slt_sort_stage.sv
// Directed bench for slt_sort_stage: reset, full/sorted/single bursts, output stalls, mid-sort reset, input ignoring.
module tb_slt_sort_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
`ifdef SLT_SORT_STATS_EN
  logic [6:0]  swap_count;
`endif

  int errors = 0;
  int checks = 0;
  int busy_cnt;
  logic [31:0] got [8];
  logic        gotl [8];

  slt_sort_stage #(.N(32), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
`ifdef SLT_SORT_STATS_EN
    ,
    .swap_count(swap_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic l);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && t < 100) begin tick(); t++; end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_ready: in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Waits for DRAIN, counting busy cycles seen on the way.
  task automatic wait_drain();
    int t = 0;
    busy_cnt = 0;
    while (!out_valid && t < 200) begin
      if (busy) busy_cnt++;
      tick();
      t++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL drain_timeout: out_valid=%b required 1", out_valid);
    end
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      got[i]  = out_data;
      gotl[i] = out_last;
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, out_last, busy} !== 4'b1000 || out_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: rdy/vld/last/busy=%b data=%h required 1000 data=0",
               {in_ready, out_valid, out_last, busy}, out_data);
    end
  endtask

  task automatic test_full_burst();
    logic [31:0] vin [8];
    logic [31:0] vexp [8];
    vin  = '{32'd5, 32'hFFFFFFFD, 32'd7, 32'd0, 32'hFFFFFFFD, 32'd2, 32'h7FFFFFFF, 32'h80000000};
    vexp = '{32'h80000000, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'd0, 32'd2, 32'd5, 32'd7, 32'h7FFFFFFF};
    for (int i = 0; i < 8; i++) push(vin[i], 1'b0);
    wait_drain();
`ifdef SLT_SORT_STATS_EN
    checks++;
    if (swap_count !== 7'd15) begin
      errors++;
      $display("FAIL full_swap_count: got %0d required 15", swap_count);
    end
`endif
    drain(8);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[i] !== vexp[i] || gotl[i] !== (i == 7)) begin
        errors++;
        $display("FAIL full_word%0d: data=%h last=%b required data=%h last=%b",
                 i, got[i], gotl[i], vexp[i], (i == 7));
      end
    end
  endtask

  task automatic test_sorted();
    for (int i = 1; i <= 4; i++) push(32'(i), i == 4);
    wait_drain();
    checks++;
    if (busy_cnt != 3) begin
      errors++;
      $display("FAIL sorted_busy_cycles: got %0d required 3", busy_cnt);
    end
`ifdef SLT_SORT_STATS_EN
    checks++;
    if (swap_count !== 7'd0) begin
      errors++;
      $display("FAIL sorted_swap_count: got %0d required 0", swap_count);
    end
`endif
    drain(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== 32'(i + 1) || gotl[i] !== (i == 3)) begin
        errors++;
        $display("FAIL sorted_word%0d: data=%h last=%b required data=%h last=%b",
                 i, got[i], gotl[i], i + 1, (i == 3));
      end
    end
  endtask

  task automatic test_single();
    push(32'd42, 1'b1);
    wait_drain();
    checks++;
    if (busy_cnt != 0 || out_data !== 32'd42 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL single_word: busy_cycles=%0d data=%h last=%b required 0 42 1",
               busy_cnt, out_data, out_last);
    end
    drain(1);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_return: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_stall();
    logic        pat [6];
    logic [31:0] acc [$];
    logic [31:0] prev;
    logic        last_seen;
    pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    push(32'd9, 1'b0);
    push(32'd8, 1'b0);
    push(32'd7, 1'b1);
    wait_drain();
    last_seen = 1'b0;
    prev = 32'd0;
    for (int k = 0; k < 6; k++) begin
      out_ready = pat[k];
      if (k > 0 && !pat[k-1]) begin
        checks++;
        if (out_data !== prev) begin
          errors++;
          $display("FAIL stall_hold%0d: data=%h required %h", k, out_data, prev);
        end
      end
      prev = out_data;
      if (out_valid && out_ready) begin
        acc.push_back(out_data);
        last_seen = out_last;
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (acc.size() != 3 || acc[0] !== 32'd7 || acc[1] !== 32'd8 || acc[2] !== 32'd9 || !last_seen) begin
      errors++;
      $display("FAIL stall_sequence: count=%0d last=%b required 7,8,9 with last", acc.size(), last_seen);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_return: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_reset_mid_sort();
    for (int i = 8; i >= 1; i--) push(32'(i), 1'b0);
    tick(); tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midsort_busy: busy=%b required 1", busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL midsort_reset: rdy/vld/busy=%b required 100", {in_ready, out_valid, busy});
    end
    push(32'd3, 1'b0);
    push(32'd1, 1'b1);
    wait_drain();
    drain(2);
    checks++;
    if (got[0] !== 32'd1 || got[1] !== 32'd3 || gotl[0] !== 1'b0 || gotl[1] !== 1'b1) begin
      errors++;
      $display("FAIL midsort_newburst: %h/%b %h/%b required 1/0 3/1", got[0], gotl[0], got[1], gotl[1]);
    end
  endtask

  task automatic test_ignore_input();
    push(32'd4, 1'b0);
    push(32'd6, 1'b0);
    push(32'd5, 1'b1);
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_data  = 32'd99;
    wait_drain();
    drain(3);
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++;
    if (got[0] !== 32'd4 || got[1] !== 32'd5 || got[2] !== 32'd6 ||
        gotl[0] !== 1'b0 || gotl[1] !== 1'b0 || gotl[2] !== 1'b1) begin
      errors++;
      $display("FAIL ignore_burst: %h %h %h last=%b%b%b required 4 5 6 last=001",
               got[0], got[1], got[2], gotl[0], gotl[1], gotl[2]);
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ignore_return: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = 32'd0;
    in_last = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_full_burst();
    test_sorted();
    test_single();
    test_stall();
    test_reset_mid_sort();
    test_ignore_input();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
